// File: rtl/st7735_fill_sequencer.sv
// -----------------------------------------------------------------------------
// st7735_fill_sequencer
//
// Rectangle-fill sequencer for an ST7735 panel. Once LCD_READY is high, a
// single-cycle START latches a window (X0,Y0)-(X1,Y1) and an RGB565 colour,
// then streams CASET / RASET / RAMWR command bytes followed by the pixel
// bytes to the SPI byte transmitter over a valid/ready handshake.
//
// Ports:
//   SYSTEM_CLK     system clock
//   SYSTEM_RST_N   asynchronous active-low reset
//   LCD_READY      panel init complete; falling while BUSY aborts the fill
//   START          single-cycle fill request (sampled only in IDLE)
//   X0/Y0/X1/Y1    inclusive window corners
//   COLOR          RGB565 fill colour
//   BUSY           fill in progress
//   DONE           one-cycle pulse on successful completion
//   ERR            one-cycle pulse on a rejected or aborted request
//   TX_BYTE/TX_DC  byte to send and its D/C flag (0 = command, 1 = data)
//   TX_VALID       TX_BYTE/TX_DC valid
//   TX_READY       SPI engine accepts the byte this cycle
//
// Build option:
//   ST7735_FILL_OFFSET_EN  when defined, CASET/RASET coordinates are sent with
//                          X_OFFSET/Y_OFFSET added (carry in the high byte).
// -----------------------------------------------------------------------------
module st7735_fill_sequencer #(
    parameter int unsigned LCD_WIDTH  = 128,
    parameter int unsigned LCD_HEIGHT = 160,
    parameter int unsigned X_OFFSET   = 2,
    parameter int unsigned Y_OFFSET   = 1
) (
    input  logic        SYSTEM_CLK,
    input  logic        SYSTEM_RST_N,
    input  logic        LCD_READY,
    input  logic        START,
    input  logic [7:0]  X0,
    input  logic [7:0]  Y0,
    input  logic [7:0]  X1,
    input  logic [7:0]  Y1,
    input  logic [15:0] COLOR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  TX_BYTE,
    output logic        TX_DC,
    output logic        TX_VALID,
    input  logic        TX_READY
);

`ifdef ST7735_FILL_OFFSET_EN
    localparam logic OFS_EN = 1'b1;
`else
    localparam logic OFS_EN = 1'b0;
`endif

    // With the offset feature disabled the offsets collapse to zero, so the
    // carry (high byte) is always 0x00 and the low byte is the raw coordinate.
    localparam logic [7:0] X_OFS = OFS_EN ? 8'(X_OFFSET) : 8'h00;
    localparam logic [7:0] Y_OFS = OFS_EN ? 8'(Y_OFFSET) : 8'h00;
    localparam logic [8:0] W_LIM = 9'(LCD_WIDTH);
    localparam logic [8:0] H_LIM = 9'(LCD_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_PIXEL,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;      // byte index inside CASET/RASET, hi/lo phase in PIXEL
    logic [14:0] pix_q, pix_d;      // pixels remaining after the current one
    logic        abort_q, abort_d;  // LCD_READY fell; finish the held byte then error out
    logic [7:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [15:0] color_q, color_d;

    logic        tx_active;
    logic        accept;
    logic        req_bad;
    logic [14:0] req_w, req_h;
    logic [8:0]  xs_sum, xe_sum, ys_sum, ye_sum;

    assign tx_active = (state_q == S_CASET) || (state_q == S_RASET) ||
                       (state_q == S_RAMWR) || (state_q == S_PIXEL);
    assign accept    = tx_active && TX_READY;

    assign req_bad = (X0 > X1) || (Y0 > Y1) ||
                     ({1'b0, X1} >= W_LIM) || ({1'b0, Y1} >= H_LIM);
    assign req_w   = 15'(X1) - 15'(X0) + 15'd1;
    assign req_h   = 15'(Y1) - 15'(Y0) + 15'd1;

    assign xs_sum = {1'b0, x0_q} + {1'b0, X_OFS};
    assign xe_sum = {1'b0, x1_q} + {1'b0, X_OFS};
    assign ys_sum = {1'b0, y0_q} + {1'b0, Y_OFS};
    assign ye_sum = {1'b0, y1_q} + {1'b0, Y_OFS};

    // State and datapath registers
    always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RST_N) begin
        if (!SYSTEM_RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pix_q   <= '0;
            abort_q <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            abort_q <= abort_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        abort_d = abort_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (START) begin
                    if (!LCD_READY || req_bad) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_CASET;
                        idx_d   = '0;
                        x0_d    = X0;
                        y0_d    = Y0;
                        x1_d    = X1;
                        y1_d    = Y1;
                        color_d = COLOR;
                        pix_d   = req_w * req_h - 15'd1;
                    end
                end
            end
            S_CASET: begin
                if (accept) begin
                    if (idx_q == 3'd4) begin
                        idx_d   = '0;
                        state_d = S_RASET;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_RASET: begin
                if (accept) begin
                    if (idx_q == 3'd4) begin
                        idx_d   = '0;
                        state_d = S_RAMWR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_RAMWR: begin
                if (accept) begin
                    idx_d   = '0;
                    state_d = S_PIXEL;
                end
            end
            S_PIXEL: begin
                if (accept) begin
                    if (!idx_q[0]) begin
                        idx_d = 3'd1;
                    end else begin
                        idx_d = '0;
                        if (pix_q == '0) begin
                            state_d = S_FINISH;
                        end else begin
                            pix_d = pix_q - 15'd1;
                        end
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort overrides normal sequencing: the presented byte is never
        // withdrawn, so wait for its acceptance and only then report the error.
        if (tx_active && (!LCD_READY || abort_q)) begin
            if (accept) begin
                state_d = S_ERROR;
                abort_d = 1'b0;
            end else begin
                abort_d = 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        BUSY     = 1'b0;
        DONE     = 1'b0;
        ERR      = 1'b0;
        TX_VALID = 1'b0;
        TX_BYTE  = 8'h00;
        TX_DC    = 1'b0;

        case (state_q)
            S_CASET: begin
                BUSY     = 1'b1;
                TX_VALID = 1'b1;
                TX_DC    = (idx_q != 3'd0);
                case (idx_q)
                    3'd0:    TX_BYTE = 8'h2A;
                    3'd1:    TX_BYTE = {7'b0, xs_sum[8]};
                    3'd2:    TX_BYTE = xs_sum[7:0];
                    3'd3:    TX_BYTE = {7'b0, xe_sum[8]};
                    default: TX_BYTE = xe_sum[7:0];
                endcase
            end
            S_RASET: begin
                BUSY     = 1'b1;
                TX_VALID = 1'b1;
                TX_DC    = (idx_q != 3'd0);
                case (idx_q)
                    3'd0:    TX_BYTE = 8'h2B;
                    3'd1:    TX_BYTE = {7'b0, ys_sum[8]};
                    3'd2:    TX_BYTE = ys_sum[7:0];
                    3'd3:    TX_BYTE = {7'b0, ye_sum[8]};
                    default: TX_BYTE = ye_sum[7:0];
                endcase
            end
            S_RAMWR: begin
                BUSY     = 1'b1;
                TX_VALID = 1'b1;
                TX_BYTE  = 8'h2C;
            end
            S_PIXEL: begin
                BUSY     = 1'b1;
                TX_VALID = 1'b1;
                TX_DC    = 1'b1;
                TX_BYTE  = idx_q[0] ? color_q[7:0] : color_q[15:8];
            end
            S_FINISH: DONE = 1'b1;
            S_ERROR:  ERR  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/st7735_fill_sequencer.md
Name: st7735_fill_sequencer

Overview:
Command/pixel sequencer that drives the ST7735 panel once the panel's init sequence reports LCD_READY. It accepts a rectangle-fill request (window corners plus RGB565 colour) and emits the CASET/RASET/RAMWR command stream, then the pixel stream. Output is a byte-level valid/ready handshake into the SPI byte transmitter. It sits between the top-level Oled logic and the ST7735 SPI engine, replacing the empty LCD_READY-gated block at top level.

Parameters:
LCD_WIDTH, 128, panel columns; legal X range is 0..LCD_WIDTH-1.
LCD_HEIGHT, 160, panel rows; legal Y range is 0..LCD_HEIGHT-1.
X_OFFSET, 2, column RAM offset; used only with ST7735_FILL_OFFSET_EN.
Y_OFFSET, 1, row RAM offset; used only with ST7735_FILL_OFFSET_EN.

Ports:
SYSTEM_CLK  input  1  system clock (12 MHz).
SYSTEM_RST_N  input  1  asynchronous active-low reset.
LCD_READY  input  1  high once the panel init sequence is complete.
START  input  1  single-cycle fill request.
X0  input  8  left column, inclusive.
Y0  input  8  top row, inclusive.
X1  input  8  right column, inclusive.
Y1  input  8  bottom row, inclusive.
COLOR  input  16  RGB565 fill colour.
BUSY  output  1  high while a fill is in progress.
DONE  output  1  one-cycle pulse on successful completion.
ERR  output  1  one-cycle pulse on a rejected or aborted request.
TX_BYTE  output  8  byte to the SPI engine.
TX_DC  output  1  0 = command byte, 1 = data byte.
TX_VALID  output  1  TX_BYTE/TX_DC are valid.
TX_READY  input  1  SPI engine accepts the byte this cycle.

Behaviour:
- Clocking and reset: one clock, SYSTEM_CLK. Reset is asynchronous, active-low, on SYSTEM_RST_N.
- Reset values: BUSY=0, DONE=0, ERR=0, TX_VALID=0, TX_BYTE=0x00, TX_DC=0, FSM in IDLE.
- Handshake:
  - A byte transfers on a cycle with TX_VALID && TX_READY.
  - While TX_VALID=1 and TX_READY=0, TX_BYTE and TX_DC are held stable.
  - A new byte may be presented the cycle after acceptance, giving 1 byte/cycle max throughput.
- START handling:
  - START is sampled only in IDLE; START while BUSY is ignored.
  - START with LCD_READY=0 → ERR pulse next cycle, stays IDLE.
- Validation, on START in IDLE with LCD_READY=1:
  - X0>X1, Y0>Y1, X1>=LCD_WIDTH or Y1>=LCD_HEIGHT → ERR pulse next cycle, no TX activity.
  - Otherwise latch X0, Y0, X1, Y1 and COLOR, and assert BUSY the next cycle.
- FSM states: IDLE → CASET → RASET → RAMWR → PIXEL → FINISH → IDLE.
- CASET: cmd 0x2A (DC=0), then data 0x00, X0, 0x00, X1 (DC=1).
- RASET: cmd 0x2B, then data 0x00, Y0, 0x00, Y1.
- RAMWR: cmd 0x2C.
- PIXEL:
  - N = (X1-X0+1)*(Y1-Y0+1) pixels.
  - Each pixel is COLOR[15:8] then COLOR[7:0], DC=1.
  - 15-bit pixel counter; max N = 20480 fits.
- FINISH:
  - Entered the cycle after the last pixel byte is accepted.
  - DONE=1 for one cycle, BUSY drops in the same cycle.
- Total bytes accepted per fill = 11 + 2N.
- Abort: LCD_READY falling while BUSY:
  - Finish the in-flight handshake (wait for TX_READY if TX_VALID=1).
  - Then deassert TX_VALID, pulse ERR, return to IDLE. DONE is not asserted.
- Reset mid-fill: TX_VALID drops immediately (async); latched request discarded.
- DONE and ERR are never asserted in the same cycle.
- BUSY is high from the cycle after an accepted START through the DONE/ERR cycle, exclusive.

Optional Feature:
ST7735_FILL_OFFSET_EN:
- Defined: CASET sends X0+X_OFFSET and X1+X_OFFSET; RASET sends Y0+Y_OFFSET and Y1+Y_OFFSET.
  - 8-bit add with the carry placed in the high data byte, i.e. the high byte is 0x00 or 0x01.
  - Validation still uses the un-offset coordinates.
- Undefined: offsets are ignored, the high bytes are always 0x00, and X_OFFSET/Y_OFFSET are unused.

Test Plan:
- Basic fill, TX_READY tied 1: LCD_READY=1, START with X0=0, Y0=0, X1=1, Y1=0, COLOR=0xF800.
  - Required byte/DC sequence: 2A/0 00/1 00/1 00/1 01/1 2B/0 00/1 00/1 00/1 00/1 2C/0 F8/1 00/1 F8/1 00/1.
  - DONE pulses exactly once, 1 cycle after the last byte; 15 bytes total.
- Backpressure: TX_READY toggled 1-of-3 cycles on a 2x2 fill with COLOR=0x1234.
  - 19 bytes, all identical to the TX_READY=1 run.
  - TX_BYTE is stable whenever TX_VALID=1 and TX_READY=0.
- Rejects, each giving an ERR pulse with TX_VALID never asserted:
  - X0=5, X1=4.
  - Y1=160.
  - START with LCD_READY=0.
- Full screen: 0..127 x 0..159.
  - Exactly 11+40960 bytes accepted.
  - A START pulse mid-fill is ignored.
  - BUSY is continuously high until DONE.
- Abort: drop LCD_READY after 20 accepted bytes with TX_READY=0 at that time.
  - The held byte completes once TX_READY=1, then ERR pulses and BUSY drops.
  - No DONE.
- Async reset: assert SYSTEM_RST_N=0 mid-PIXEL between clock edges.
  - TX_VALID and BUSY go 0 without waiting for a clock edge.
  - After release, a new 1x1 fill produces exactly 13 bytes.
  - With ST7735_FILL_OFFSET_EN and X0=X1=0, Y0=Y1=0: CASET data is 00 02 00 02 and RASET data is 00 01 00 01.
